// File: rtl/video_stream_pkg.sv
// rtl/video_stream_pkg.sv - shared types and defaults for the video NOT stream stage
package video_stream_pkg;

   localparam int DEFAULT_DATA_WIDTH = 24;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_RUN      = 2'd2
   } state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - generic 2-entry registered AXIS slice
// Output register plus one skid entry; upstream ready is registered as "skid not full".
module axis_skid_buffer #(
   parameter int WIDTH = 26
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] s_tdata_i,
   input  logic             s_tvalid_i,
   output logic             s_tready_o,
   output logic [WIDTH-1:0] m_tdata_o,
   output logic             m_tvalid_o,
   input  logic             m_tready_i
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic             in_ready_q;
   logic             push, pop;

   assign push = s_tvalid_i && in_ready_q;
   assign pop  = out_valid_q && m_tready_i;

   always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (pop || !out_valid_q) begin
         // Output slot frees up: the older skid entry moves first to keep order.
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = push;
            if (push) skid_data_d = s_tdata_i;
         end else begin
            out_valid_d = push;
            if (push) out_data_d = s_tdata_i;
         end
      end else if (push) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_tdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

   assign s_tready_o = in_ready_q;
   assign m_tdata_o  = out_data_q;
   assign m_tvalid_o = out_valid_q;

endmodule

// File: rtl/video_stream_not_core.sv
// rtl/video_stream_not_core.sv - AXIS video stage inverting every pixel, gated on frame edges
// FSM decides per accepted beat whether to forward; forwarded beats go through a skid slice.
module video_stream_not_core
   import video_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  AXIS_ACLK,
   input  logic                  AXIS_ARESETN,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                  S_AXIS_TUSER,
   input  logic                  S_AXIS_TLAST,
   input  logic                  S_AXIS_TVALID,
   output logic                  S_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                  M_AXIS_TUSER,
   output logic                  M_AXIS_TLAST,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   state_e                 state_q;
   logic                   busy_q;
   logic [CNT_WIDTH-1:0]   frame_count_q;
   logic                   acc, fwd;
   logic [DATA_WIDTH+1:0]  skid_in, skid_out;

   assign acc = S_AXIS_TVALID && S_AXIS_TREADY;

   // Beats that are not forwarded are still accepted and simply dropped.
   always_comb begin
      fwd = 1'b0;
      case (state_q)
         ST_WAIT_SOF: fwd = S_AXIS_TUSER && start;
         ST_RUN:      fwd = !(S_AXIS_TUSER && !start);
         default:     fwd = 1'b0;
      endcase
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q       <= ST_IDLE;
         busy_q        <= 1'b0;
         frame_count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_WAIT_SOF;
                  busy_q  <= 1'b1;
               end
            end
            ST_WAIT_SOF: begin
               if (!start) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (acc && S_AXIS_TUSER) begin
                  state_q       <= ST_RUN;
                  frame_count_q <= frame_count_q + 1'b1;
               end
            end
            ST_RUN: begin
               // start is only honoured at the next SOF so frames are never truncated.
               if (acc && S_AXIS_TUSER) begin
                  if (start) begin
                     frame_count_q <= frame_count_q + 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign skid_in = {S_AXIS_TUSER, S_AXIS_TLAST, ~S_AXIS_TDATA};

   axis_skid_buffer #(
      .WIDTH(DATA_WIDTH + 2)
   ) u_skid (
      .clk_i      (AXIS_ACLK),
      .rst_n_i    (AXIS_ARESETN),
      .s_tdata_i  (skid_in),
      .s_tvalid_i (S_AXIS_TVALID && fwd),
      .s_tready_o (S_AXIS_TREADY),
      .m_tdata_o  (skid_out),
      .m_tvalid_o (M_AXIS_TVALID),
      .m_tready_i (M_AXIS_TREADY)
   );

   assign M_AXIS_TUSER = skid_out[DATA_WIDTH+1];
   assign M_AXIS_TLAST = skid_out[DATA_WIDTH];
   assign M_AXIS_TDATA = skid_out[DATA_WIDTH-1:0];
   assign busy         = busy_q;
   assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_video_stream_not_core.sv
// tb/tb_video_stream_not_core.sv - self-checking bench for video_stream_not_core
module tb_video_stream_not_core;

   localparam int DW = 24;
   localparam int CW = 4;

   logic          AXIS_ACLK = 1'b0;
   logic          AXIS_ARESETN;
   logic          start;
   logic [DW-1:0] S_AXIS_TDATA;
   logic          S_AXIS_TUSER, S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
   logic [DW-1:0] M_AXIS_TDATA;
   logic          M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;
   logic          busy;
   logic [CW-1:0] frame_count;

   video_stream_not_core #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .AXIS_ACLK     (AXIS_ACLK),
      .AXIS_ARESETN  (AXIS_ARESETN),
      .start         (start),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TUSER  (S_AXIS_TUSER),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TUSER  (M_AXIS_TUSER),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .busy          (busy),
      .frame_count   (frame_count)
   );

   always #5 AXIS_ACLK = ~AXIS_ACLK;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference: a frame is forwarded iff, when its SOF is accepted, start is high
   // and either the previous frame was being forwarded or start was already high a cycle earlier.
   logic [DW+1:0] exp_q[$];
   logic [DW+1:0] popped[$];
   bit            fwd_frame = 0;
   bit            prev_start = 0;
   int            exp_cnt = 0;
   int            tready_low = 0;
   bit            prev_stall = 0;
   logic [DW+1:0] prev_out;

   always @(negedge AXIS_ACLK) begin
      if (!AXIS_ARESETN) begin
         chk("rst_m_tvalid", M_AXIS_TVALID, 0);
         exp_q.delete();
         fwd_frame  = 0;
         prev_start = 0;
         exp_cnt    = 0;
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_hold_valid", M_AXIS_TVALID, 1);
            chk("stall_hold_data", {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}, prev_out);
         end
         prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
         prev_out   = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
         chk("frame_count", frame_count, exp_cnt % (1 << CW));
         if (!S_AXIS_TREADY) tready_low++;
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}, 32'hDEAD_BEEF);
            end else begin
               chk("out_beat", {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}, exp_q.pop_front());
            end
            popped.push_back({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA});
         end
         if (S_AXIS_TVALID && S_AXIS_TREADY) begin
            if (S_AXIS_TUSER) begin
               fwd_frame = start && (fwd_frame || prev_start);
               if (fwd_frame) exp_cnt++;
            end
            if (fwd_frame) exp_q.push_back({S_AXIS_TUSER, S_AXIS_TLAST, ~S_AXIS_TDATA});
         end
         prev_start = start;
      end
   end

   bit ready_rand = 0;
   bit ready_lvl  = 1;
   always @(posedge AXIS_ACLK) begin
      #1;
      M_AXIS_TREADY = ready_rand ? ($urandom_range(1, 0) == 1) : ready_lvl;
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
      bit got = 0;
      S_AXIS_TDATA  = d;
      S_AXIS_TUSER  = u;
      S_AXIS_TLAST  = l;
      S_AXIS_TVALID = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge AXIS_ACLK);
         if (S_AXIS_TREADY && AXIS_ARESETN) begin
            got = 1;
            break;
         end
      end
      @(posedge AXIS_ACLK);
      #1;
      S_AXIS_TVALID = 1'b0;
      chk("send_accept", got, 1);
   endtask

   task automatic send_frame(input int w, input int h, inout logic [DW-1:0] d);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            send_beat(d, (x == 0 && y == 0), (x == w - 1));
            d = d + 1'b1;
         end
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge AXIS_ACLK);
         if (exp_q.size() == 0 && !M_AXIS_TVALID) begin
            done = 1;
            break;
         end
      end
      chk("drain", done, 1);
      @(posedge AXIS_ACLK);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge AXIS_ACLK);
      #1;
      AXIS_ARESETN = 1'b0;
      repeat (2) @(posedge AXIS_ACLK);
      #1;
      AXIS_ARESETN = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [DW-1:0] d;
      int p0, t0, nlast;

      AXIS_ARESETN  = 1'b0;
      start         = 1'b0;
      S_AXIS_TDATA  = '0;
      S_AXIS_TUSER  = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TVALID = 1'b0;
      M_AXIS_TREADY = 1'b1;
      repeat (2) @(posedge AXIS_ACLK);
      #1;
      chk("reset_tvalid", M_AXIS_TVALID, 0);
      chk("reset_tdata", M_AXIS_TDATA, 0);
      chk("reset_busy", busy, 0);
      chk("reset_count", frame_count, 0);
      chk("reset_tready", S_AXIS_TREADY, 0);
      AXIS_ARESETN = 1'b1;
      @(posedge AXIS_ACLK);
      #1;
      chk("tready_after_reset", S_AXIS_TREADY, 1);

      // 1: start low, two 4x2 frames are swallowed without stalling
      p0 = popped.size();
      t0 = tready_low;
      d  = 24'h000010;
      send_frame(4, 2, d);
      send_frame(4, 2, d);
      drain();
      chk("t1_no_output", popped.size() - p0, 0);
      chk("t1_tready_high", tready_low - t0, 0);
      chk("t1_count", frame_count, 0);

      // 2: start rises mid-frame, forwarding begins at the next SOF
      send_beat(24'h000020, 1'b0, 1'b0);
      send_beat(24'h000021, 1'b0, 1'b1);
      start = 1'b1;
      send_beat(24'h0000FF, 1'b0, 1'b0);
      send_beat(24'h0000FF, 1'b0, 1'b1);
      p0 = popped.size();
      send_beat(24'h0000FF, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) send_beat(24'h0000FF, 1'b0, (i % 4) == 3);
      drain();
      chk("t2_beats", popped.size() - p0, 8);
      if (popped.size() > p0) chk("t2_first_beat", popped[p0], {1'b1, 1'b0, 24'hFFFF00});
      chk("t2_count", frame_count, 1);
      chk("t2_busy", busy, 1);

      // 3: random sink stalls over three 8x4 frames
      ready_rand = 1;
      p0 = popped.size();
      d  = 24'h100000;
      for (int f = 0; f < 3; f++) send_frame(8, 4, d);
      drain();
      ready_rand = 0;
      nlast = 0;
      for (int i = p0; i < popped.size(); i++) if (popped[i][DW]) nlast++;
      chk("t3_beats", popped.size() - p0, 96);
      chk("t3_tlast", nlast, 12);
      chk("t3_count", frame_count, 4);

      // 4: start drops at beat 5 of a 16-beat frame; frame completes, next SOF is dropped
      p0 = popped.size();
      for (int i = 0; i < 16; i++) begin
         send_beat(24'h200000 + i, i == 0, i == 15);
         if (i == 4) start = 1'b0;
      end
      d = 24'h300000;
      send_frame(4, 1, d);
      drain();
      chk("t4_beats", popped.size() - p0, 16);
      chk("t4_busy", busy, 0);
      chk("t4_count", frame_count, 5);

      // 5: reset with the slice full, then re-sync on the next SOF
      start     = 1'b1;
      ready_lvl = 0;
      repeat (2) @(posedge AXIS_ACLK);
      #1;
      send_beat(24'h400000, 1'b1, 1'b0);
      send_beat(24'h400001, 1'b0, 1'b0);
      @(negedge AXIS_ACLK);
      chk("t5_full_tready", S_AXIS_TREADY, 0);
      chk("t5_full_tvalid", M_AXIS_TVALID, 1);
      @(posedge AXIS_ACLK);
      #3;
      AXIS_ARESETN = 1'b0;
      #1;
      chk("t5_rst_tvalid", M_AXIS_TVALID, 0);
      chk("t5_rst_count", frame_count, 0);
      chk("t5_rst_tready", S_AXIS_TREADY, 0);
      repeat (2) @(posedge AXIS_ACLK);
      #1;
      AXIS_ARESETN = 1'b1;
      ready_lvl    = 1;
      p0 = popped.size();
      for (int i = 0; i < 3; i++) send_beat(24'h500000 + i, 1'b0, i == 2);
      d = 24'h600000;
      send_frame(4, 1, d);
      drain();
      chk("t5_beats", popped.size() - p0, 4);
      if (popped.size() > p0) chk("t5_first_beat", popped[p0], {1'b1, 1'b0, 24'h9FFFFF});
      chk("t5_count", frame_count, 1);

      // 6: seventeen one-beat frames wrap a 4-bit counter to 1
      pulse_reset();
      repeat (2) @(posedge AXIS_ACLK);
      #1;
      p0 = popped.size();
      for (int i = 0; i < 17; i++) send_beat(24'h700000 + i, 1'b1, 1'b1);
      drain();
      chk("t6_beats", popped.size() - p0, 17);
      chk("t6_count_wrap", frame_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
